// File: rtl/dram_cmd_decoder.sv
// DDR4 command-bus receiver: decode, per-bank open tracking, violation flags, CL/CWL data windows.
// One-cycle registered outputs, no backpressure; DRAM_CMD_DEC_TIMING_CHECK_EN adds tRCD/tRP/tRAS/tRFC checks.
package dram_pkg;
  localparam int RANK_BITS       = 1;
  localparam int BANK_GROUP_BITS = 2;
  localparam int BANK_BITS       = 2;
  localparam int ROW_BITS        = 18;
  localparam int COLUMN_BITS     = 10;
  localparam int ADDR_BITS       = 14;
endpackage

module dram_cmd_decoder
  import dram_pkg::*;
#(
  parameter int T_RCD     = 16,
  parameter int T_RP      = 16,
  parameter int T_RAS     = 39,
  parameter int T_RFC     = 256,
  parameter int CL        = 16,
  parameter int CWL       = 12,
  parameter int BURST_LEN = 8
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic                                      CS_n,
  input  logic                                      ACT_n,
  input  logic                                      RAS_n_A16,
  input  logic                                      CAS_n_A15,
  input  logic                                      WE_n_A14,
  input  logic [BANK_GROUP_BITS-1:0]                BG,
  input  logic [BANK_BITS-1:0]                      BA,
  input  logic [ADDR_BITS-1:0]                      ADDR,
  input  logic                                      ADDR_17,
  output logic                                      cmd_valid,
  output logic [3:0]                                cmd_code,
  output logic [BANK_GROUP_BITS+BANK_BITS-1:0]      cmd_bank,
  output logic [ROW_BITS-1:0]                       cmd_row,
  output logic [COLUMN_BITS-1:0]                    cmd_col,
  output logic                                      cmd_ap,
  output logic [(1<<(BANK_GROUP_BITS+BANK_BITS))-1:0] bank_open,
  output logic                                      err_valid,
  output logic [2:0]                                err_code,
  output logic                                      rd_window,
  output logic                                      wr_window
);
  localparam int BW  = BANK_GROUP_BITS + BANK_BITS;
  localparam int NB  = 1 << BW;
  localparam int HB  = BURST_LEN / 2;
  localparam int RDD = CL + HB - 1;
  localparam int WRD = CWL + HB - 1;

  localparam logic [3:0] C_DES = 4'd0, C_NOP = 4'd1, C_ACT = 4'd2, C_RD = 4'd3,
                         C_WR = 4'd4, C_PRE = 4'd5, C_PREA = 4'd6, C_REF = 4'd7,
                         C_MRS = 4'd8, C_ZQC = 4'd9, C_RFU = 4'd10;

  logic [3:0]            code;
  logic [BW-1:0]         bank;
  logic [ADDR_BITS+3:0]  row_full;
  logic [ROW_BITS-1:0]   row;
  logic                  a10;
  logic                  is_act, is_rd, is_wr, is_rdwr, is_pre, is_prea, is_ref, is_state_cmd;
  logic                  any_open, accept;
  logic [2:0]            err_c;
  logic [NB-1:0]         open_v, close_v;

  logic                  cmd_valid_q, cmd_valid_d;
  logic [3:0]            cmd_code_q, cmd_code_d;
  logic [BW-1:0]         cmd_bank_q, cmd_bank_d;
  logic [ROW_BITS-1:0]   cmd_row_q, cmd_row_d;
  logic [COLUMN_BITS-1:0] cmd_col_q, cmd_col_d;
  logic                  cmd_ap_q, cmd_ap_d;
  logic [NB-1:0]         bank_open_q, bank_open_d;
  logic                  err_valid_q, err_valid_d;
  logic [2:0]            err_code_q, err_code_d;
  logic [RDD-1:0]        rd_sr_q, rd_sr_d;
  logic [WRD-1:0]        wr_sr_q, wr_sr_d;
  logic                  rd_window_q, rd_window_d;
  logic                  wr_window_q, wr_window_d;

  assign bank     = {BG, BA};
  assign a10      = ADDR[10];
  assign row_full = {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR};
  assign row      = row_full[ROW_BITS-1:0];
  assign any_open = |bank_open_q;

  always_comb begin
    code = C_DES;
    if (!CS_n) begin
      if (!ACT_n) begin
        code = C_ACT;
      end else begin
        case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000:  code = C_MRS;
          3'b001:  code = C_REF;
          3'b010:  code = a10 ? C_PREA : C_PRE;
          3'b011:  code = C_RFU;
          3'b100:  code = C_WR;
          3'b101:  code = C_RD;
          3'b110:  code = C_ZQC;
          default: code = C_NOP;
        endcase
      end
    end
  end

  assign is_act       = (code == C_ACT);
  assign is_rd        = (code == C_RD);
  assign is_wr        = (code == C_WR);
  assign is_rdwr      = is_rd | is_wr;
  assign is_pre       = (code == C_PRE);
  assign is_prea      = (code == C_PREA);
  assign is_ref       = (code == C_REF);
  assign is_state_cmd = is_ref | (code == C_MRS) | (code == C_ZQC);

`ifdef DRAM_CMD_DEC_TIMING_CHECK_EN
  localparam int RCDW = $clog2(T_RCD + 1);
  localparam int RPW  = $clog2(T_RP + 1);
  localparam int RASW = $clog2(T_RAS + 1);
  localparam int RFCW = $clog2(T_RFC + 1);
  localparam logic [RCDW-1:0] RCD_LD = RCDW'(T_RCD - 1);
  localparam logic [RPW-1:0]  RP_LD  = RPW'(T_RP - 1);
  localparam logic [RASW-1:0] RAS_LD = RASW'(T_RAS - 1);
  localparam logic [RFCW-1:0] RFC_LD = RFCW'(T_RFC - 1);

  // Counters load T-1 on the accepting edge, so a zero count at a later edge means spacing >= T.
  logic [RCDW-1:0] rcd_q [NB];
  logic [RCDW-1:0] rcd_d [NB];
  logic [RPW-1:0]  rp_q  [NB];
  logic [RPW-1:0]  rp_d  [NB];
  logic [RASW-1:0] ras_q [NB];
  logic [RASW-1:0] ras_d [NB];
  logic [RFCW-1:0] rfc_q, rfc_d;
  logic            ras_viol, is_chk;

  assign is_chk = (code != C_DES) && (code != C_NOP) && (code != C_RFU);

  always_comb begin
    ras_viol = 1'b0;
    if ((is_pre || (is_rdwr && a10)) && bank_open_q[bank] && (ras_q[bank] != '0))
      ras_viol = 1'b1;
    if (is_prea) begin
      for (int i = 0; i < NB; i++) begin
        if (bank_open_q[i] && (ras_q[i] != '0)) ras_viol = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      rcd_d[i] = (rcd_q[i] != '0) ? rcd_q[i] - RCDW'(1) : '0;
      rp_d[i]  = (rp_q[i]  != '0) ? rp_q[i]  - RPW'(1)  : '0;
      ras_d[i] = (ras_q[i] != '0) ? ras_q[i] - RASW'(1) : '0;
      if (open_v[i]) begin
        rcd_d[i] = RCD_LD;
        ras_d[i] = RAS_LD;
      end
      if (close_v[i]) rp_d[i] = RP_LD;
    end
    rfc_d = (rfc_q != '0) ? rfc_q - RFCW'(1) : '0;
    if (accept && is_ref) rfc_d = RFC_LD;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      rcd_q[i] <= nRST ? rcd_d[i] : '0;
      rp_q[i]  <= nRST ? rp_d[i]  : '0;
      ras_q[i] <= nRST ? ras_d[i] : '0;
    end
    rfc_q <= nRST ? rfc_d : '0;
  end
`endif

  // Later assignments take priority, so the list runs from lowest to highest precedence.
  always_comb begin
    err_c = 3'd0;
`ifdef DRAM_CMD_DEC_TIMING_CHECK_EN
    if (is_act && (rp_q[bank] != '0))   err_c = 3'd4;
    if (ras_viol)                        err_c = 3'd5;
    if (is_rdwr && (rcd_q[bank] != '0)) err_c = 3'd3;
`endif
    if (is_rdwr && !bank_open_q[bank])  err_c = 3'd2;
    if (is_act && bank_open_q[bank])    err_c = 3'd1;
    if (is_state_cmd && any_open)       err_c = 3'd6;
`ifdef DRAM_CMD_DEC_TIMING_CHECK_EN
    if (is_chk && (rfc_q != '0))        err_c = 3'd7;
`endif
  end

  always_comb begin
    cmd_valid_d = (code != C_DES) && (code != C_NOP);
    accept      = cmd_valid_d && (err_c == 3'd0);
    open_v      = '0;
    close_v     = '0;
    if (accept) begin
      if (is_act) open_v[bank] = 1'b1;
      if (is_pre || (is_rdwr && a10)) close_v[bank] = bank_open_q[bank];
      if (is_prea) close_v = bank_open_q;
    end
    bank_open_d = (bank_open_q & ~close_v) | open_v;
    cmd_code_d  = code;
    cmd_bank_d  = cmd_valid_d ? bank : '0;
    cmd_row_d   = is_act ? row : '0;
    cmd_col_d   = is_rdwr ? ADDR[COLUMN_BITS-1:0] : '0;
    cmd_ap_d    = is_rdwr & a10;
    err_valid_d = (err_c != 3'd0);
    err_code_d  = err_c;
    rd_sr_d     = {rd_sr_q[RDD-2:0], accept & is_rd};
    wr_sr_d     = {wr_sr_q[WRD-2:0], accept & is_wr};
    // A burst accepted at edge t sits at bit k after edge t+k; the window covers CL-1 .. CL+HB-2.
    rd_window_d = |rd_sr_d[RDD-1:CL-1];
    wr_window_d = |wr_sr_d[WRD-1:CWL-1];
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_ap_q    <= 1'b0;
      bank_open_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      rd_sr_q     <= '0;
      wr_sr_q     <= '0;
      rd_window_q <= 1'b0;
      wr_window_q <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      cmd_ap_q    <= cmd_ap_d;
      bank_open_q <= bank_open_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      rd_sr_q     <= rd_sr_d;
      wr_sr_q     <= wr_sr_d;
      rd_window_q <= rd_window_d;
      wr_window_q <= wr_window_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign cmd_ap    = cmd_ap_q;
  assign bank_open = bank_open_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign rd_window = rd_window_q;
  assign wr_window = wr_window_q;
endmodule

// File: tb/tb_dram_cmd_decoder.sv
// Directed bench for dram_cmd_decoder; expectations follow DRAM_CMD_DEC_TIMING_CHECK_EN when defined.
module tb_dram_cmd_decoder;
`ifdef DRAM_CMD_DEC_TIMING_CHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif

  logic        CLK, nRST;
  logic        CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  BG, BA;
  logic [13:0] ADDR;
  logic        ADDR_17;
  logic        cmd_valid, cmd_ap, err_valid, rd_window, wr_window;
  logic [3:0]  cmd_code, cmd_bank;
  logic [17:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] bank_open;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;

  dram_cmd_decoder dut (
    .CLK(CLK), .nRST(nRST), .CS_n(CS_n), .ACT_n(ACT_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .BG(BG), .BA(BA), .ADDR(ADDR), .ADDR_17(ADDR_17),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap),
    .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code),
    .rd_window(rd_window), .wr_window(wr_window)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cmd(input string tag, input logic v, input logic [3:0] code,
                         input logic [2:0] ec, input logic [15:0] open);
    check({tag, ".valid"}, 32'(cmd_valid), 32'(v));
    check({tag, ".code"},  32'(cmd_code),  32'(code));
    check({tag, ".errv"},  32'(err_valid), 32'(ec != 3'd0));
    check({tag, ".errc"},  32'(err_code),  32'(ec));
    check({tag, ".open"},  32'(bank_open), 32'(open));
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic des();
    CS_n = 1'b1; ACT_n = 1'b1;
    {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b111;
    BG = '0; BA = '0; ADDR = '0; ADDR_17 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic act_n, input logic [2:0] rcw, input logic [3:0] bk,
                       input logic [17:0] a);
    CS_n = 1'b0; ACT_n = act_n;
    {RAS_n_A16, CAS_n_A15, WE_n_A14} = act_n ? rcw : a[16:14];
    BG = bk[3:2]; BA = bk[1:0]; ADDR = a[13:0]; ADDR_17 = a[17];
    step();
    des();
  endtask

  task automatic act(input logic [3:0] bk, input logic [17:0] r); drive(1'b0, 3'b000, bk, r); endtask
  task automatic rd(input logic [3:0] bk, input logic [9:0] c, input logic ap); drive(1'b1, 3'b101, bk, {7'd0, ap, c}); endtask
  task automatic wr(input logic [3:0] bk, input logic [9:0] c, input logic ap); drive(1'b1, 3'b100, bk, {7'd0, ap, c}); endtask
  task automatic pre(input logic [3:0] bk); drive(1'b1, 3'b010, bk, 18'h00000); endtask
  task automatic prea(); drive(1'b1, 3'b010, 4'd0, 18'h00400); endtask
  task automatic refr(); drive(1'b1, 3'b001, 4'd0, 18'h00000); endtask

  initial begin
    logic [15:0] o3, o4, o5;
    int cnt, first, last;

    // Reset with an ACT on the pins: nothing may be decoded or opened.
    des();
    nRST = 1'b0; CS_n = 1'b0; ACT_n = 1'b0; BG = 2'd0; BA = 2'd3;
    idle(2);
    check("rst.valid", 32'(cmd_valid), 32'd0);
    check("rst.code",  32'(cmd_code),  32'd0);
    check("rst.open",  32'(bank_open), 32'd0);
    check("rst.errv",  32'(err_valid), 32'd0);
    check("rst.rdwin", 32'(rd_window), 32'd0);
    check("rst.wrwin", 32'(wr_window), 32'd0);
    des();
    nRST = 1'b1;
    step();

    // Decode of the non-bank commands while all banks are idle.
    drive(1'b1, 3'b000, 4'd0, 18'd0); chk_cmd("mrs", 1'b1, 4'd8, 3'd0, 16'h0000);
    drive(1'b1, 3'b110, 4'd0, 18'd0); chk_cmd("zqc", 1'b1, 4'd9, 3'd0, 16'h0000);
    drive(1'b1, 3'b011, 4'd0, 18'd0); chk_cmd("rfu", 1'b1, 4'd10, 3'd0, 16'h0000);
    drive(1'b1, 3'b111, 4'd0, 18'd0); chk_cmd("nop", 1'b0, 4'd1, 3'd0, 16'h0000);
    step();                           chk_cmd("des", 1'b0, 4'd0, 3'd0, 16'h0000);

    // ACT bank 5, RD at exactly tRCD, read window for 4 cycles.
    act(4'd5, 18'h01234);
    chk_cmd("act5", 1'b1, 4'd2, 3'd0, 16'h0020);
    check("act5.row",  32'(cmd_row),  32'h1234);
    check("act5.bank", 32'(cmd_bank), 32'd5);
    idle(15);
    rd(4'd5, 10'h040, 1'b0);
    chk_cmd("rd5", 1'b1, 4'd3, 3'd0, 16'h0020);
    check("rd5.col", 32'(cmd_col), 32'h40);
    check("rd5.ap",  32'(cmd_ap),  32'd0);
    for (int j = 1; j <= 22; j++) begin
      step();
      check("rd5.win", 32'(rd_window), 32'((j >= 15) && (j <= 18)));
    end

    // tRCD boundary on bank 2, row uses the A17..A14 pins.
    act(4'd2, 18'h2C0F5);
    chk_cmd("act2", 1'b1, 4'd2, 3'd0, 16'h0024);
    check("act2.row", 32'(cmd_row), 32'h2C0F5);
    idle(14);
    rd(4'd2, 10'h007, 1'b0);
    chk_cmd("rd2.early", 1'b1, 4'd3, TC ? 3'd3 : 3'd0, 16'h0024);
    rd(4'd2, 10'h008, 1'b0);
    chk_cmd("rd2.ok", 1'b1, 4'd3, 3'd0, 16'h0024);
    cnt = 0;
    for (int j = 0; j < 25; j++) begin
      step();
      if (rd_window) cnt++;
    end
    check("rd2.wincnt", 32'(cnt), TC ? 32'd4 : 32'd5);

    // tRAS and tRP boundaries on bank 0.
    act(4'd0, 18'h00777);
    chk_cmd("act0", 1'b1, 4'd2, 3'd0, 16'h0025);
    idle(37);
    pre(4'd0);
    chk_cmd("pre0.early", 1'b1, 4'd5, TC ? 3'd5 : 3'd0, TC ? 16'h0025 : 16'h0024);
    pre(4'd0);
    chk_cmd("pre0.ok", 1'b1, 4'd5, 3'd0, 16'h0024);
    idle(14);
    act(4'd0, 18'h00777);
    o3 = TC ? 16'h0024 : 16'h0025;
    chk_cmd("act0.rp", 1'b1, 4'd2, TC ? 3'd4 : 3'd0, o3);

    // State errors 6, 1, 2; then PREA, REF and the tRFC boundary.
    o4 = o3 | 16'h0002;
    act(4'd1, 18'h00100);          chk_cmd("act1", 1'b1, 4'd2, 3'd0, o4);
    refr();                        chk_cmd("ref.open", 1'b1, 4'd7, 3'd6, o4);
    act(4'd5, 18'h00001);          chk_cmd("act5.open", 1'b1, 4'd2, 3'd1, o4);
    rd(4'd7, 10'h001, 1'b0);       chk_cmd("rd7.idle", 1'b1, 4'd3, 3'd2, o4);
    drive(1'b1, 3'b000, 4'd0, 18'd0); chk_cmd("mrs.open", 1'b1, 4'd8, 3'd6, o4);
    idle(40);
    prea();                        chk_cmd("prea", 1'b1, 4'd6, 3'd0, 16'h0000);
    idle(15);
    refr();                        chk_cmd("ref.ok", 1'b1, 4'd7, 3'd0, 16'h0000);
    idle(99);
    act(4'd3, 18'h00003);
    chk_cmd("act3.rfc", 1'b1, 4'd2, TC ? 3'd7 : 3'd0, TC ? 16'h0000 : 16'h0008);
    idle(155);
    o5 = TC ? 16'h0010 : 16'h0018;
    act(4'd4, 18'h00004);          chk_cmd("act4.rfc", 1'b1, 4'd2, 3'd0, o5);

    // Two reads 4 apart merge into one 8-cycle window.
    idle(15);
    rd(4'd4, 10'h011, 1'b0);       chk_cmd("rd4a", 1'b1, 4'd3, 3'd0, o5);
    idle(3);
    rd(4'd4, 10'h012, 1'b0);       chk_cmd("rd4b", 1'b1, 4'd3, 3'd0, o5);
    cnt = 0; first = -1; last = -1;
    for (int j = 5; j <= 30; j++) begin
      step();
      if (rd_window) begin
        cnt++;
        if (first < 0) first = j;
        last = j;
      end
    end
    check("rd4.wincnt",  32'(cnt),   32'd8);
    check("rd4.winfirst", 32'(first), 32'd15);
    check("rd4.winlast",  32'(last),  32'd22);

    // Write with auto-precharge closes the bank and opens a write window.
    wr(4'd4, 10'h010, 1'b1);
    chk_cmd("wr4ap", 1'b1, 4'd4, 3'd0, o5 & 16'hFFEF);
    check("wr4ap.ap",  32'(cmd_ap),  32'd1);
    check("wr4ap.col", 32'(cmd_col), 32'h10);
    for (int j = 1; j <= 20; j++) begin
      step();
      check("wr4.win", 32'(wr_window), 32'((j >= 11) && (j <= 14)));
    end
    rd(4'd4, 10'h000, 1'b0);
    chk_cmd("rd4.closed", 1'b1, 4'd3, 3'd2, o5 & 16'hFFEF);

    // Reset in the middle of a read burst.
    act(4'd6, 18'h00006);
    idle(15);
    rd(4'd6, 10'h020, 1'b0);
    idle(16);
    check("rd6.win", 32'(rd_window), 32'd1);
    nRST = 1'b0;
    step();
    chk_cmd("rst2", 1'b0, 4'd0, 3'd0, 16'h0000);
    check("rst2.rdwin", 32'(rd_window), 32'd0);
    check("rst2.wrwin", 32'(wr_window), 32'd0);
    check("rst2.bank",  32'(cmd_bank),  32'd0);
    nRST = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      check("rst2.rdwin.after", 32'(rd_window), 32'd0);
    end
    rd(4'd6, 10'h020, 1'b0);
    chk_cmd("rd6.afterrst", 1'b1, 4'd3, 3'd2, 16'h0000);

    // Reset in the middle of tRFC clears the refresh hold-off.
    refr();
    chk_cmd("ref2", 1'b1, 4'd7, 3'd0, 16'h0000);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    act(4'd1, 18'h00001);
    chk_cmd("act1.afterrst", 1'b1, 4'd2, 3'd0, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
